uart_tx_piso: RTL and testbench

Per-port serial transmitter for the Hydra link: accepts one 63-bit packet word at a time from the Hydra router's per-UART load strobe and data bus. Appends an odd-parity bit to form a WIDTH-bit packet, frames it with start and stop bits, and shifts it out LSB first on a single wire. Four instances sit between the Hydra router's tx_data0..3 / ld_tx_data_uart[3:0] outputs and the chip's PISO pads. Each instance feeds its tx_busy back to the router's tx_busy[3:0].

---
 rtl/uart_tx_piso.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_piso.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_piso.sv
// Hydra link per-port serial transmitter.
// Takes a WIDTH-1 bit word through a one-deep holding register, appends an
// odd-parity bit, frames it with a start bit (0) and a stop bit (1), and
// shifts the frame out LSB first. Each serial bit lasts CLK_DIV clock cycles.
// The line output is registered and trails the internal state by one cycle.
// CLK_DIV must lie in 1..255 so that the divider fits in eight bits.
module uart_tx_piso #(
  parameter int WIDTH   = 64,
  parameter int CLK_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-2:0] tx_data,
  input  logic             ld_tx_data,
  input  logic             tx_enable,
  output logic             tx_out,
  output logic             tx_busy,
  output logic             tx_overflow
);

  // A divider of at least one bit keeps CLK_DIV=1 legal; it then never counts.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // The bit counter has to reach WIDTH-2, the index of the last data bit.
  localparam int BIT_W = (WIDTH > 2) ? $clog2(WIDTH - 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   div_d;
  logic [BIT_W-1:0]   bit_q;
  logic [BIT_W-1:0]   bit_d;
  logic [WIDTH-1:0]   shift_q;
  logic [WIDTH-1:0]   shift_d;
  logic               hold_valid_q;
  logic               hold_valid_d;
  logic [WIDTH-2:0]   hold_data_q;
  logic [WIDTH-2:0]   hold_data_d;
  logic               tx_out_q;
  logic               tx_out_d;
  logic               overflow_q;
  logic               overflow_d;

  logic               period_end;
  logic               transfer;
  logic               load_req;
  logic               accept;

  assign period_end = (div_q == DIV_LAST);
  assign load_req   = ld_tx_data & tx_enable;

  // Frame sequencing: state, bit divider, data bit counter and shift register.
  // A transfer moves the held word plus its parity into the shift register and
  // restarts the frame at START; STOP can transfer directly so that
  // consecutive frames leave no idle gap on the line.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    transfer = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_valid_q && tx_enable) begin
          transfer = 1'b1;
        end
      end
      START: begin
        if (period_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (period_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = PARITY;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (period_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (period_end) begin
          if (hold_valid_q && tx_enable) begin
            transfer = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_q != IDLE) begin
      div_d = period_end ? '0 : div_q + 1'b1;
    end

    if (transfer) begin
      state_d = START;
      div_d   = '0;
      bit_d   = '0;
      shift_d = {~^hold_data_q, hold_data_q};
    end
  end

  // Holding register: a load is taken when the slot is empty or is being
  // emptied by a transfer in the same cycle; otherwise it is dropped with an
  // overflow pulse. Loads while the port is disabled are ignored silently.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    accept       = load_req & (~hold_valid_q | transfer);
    overflow_d   = load_req & hold_valid_q & ~transfer;

    if (transfer) begin
      hold_valid_d = 1'b0;
    end
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_data_d  = tx_data;
    end
  end

  // Line value for the current state; registered below, hence the one-cycle
  // lag between entering START and the start bit appearing on tx_out.
  // After all data shifts the parity bit sits in shift_q[0].
  always_comb begin
    tx_out_d = 1'b1;
    case (state_q)
      IDLE:    tx_out_d = 1'b1;
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = shift_q[0];
      PARITY:  tx_out_d = shift_q[0];
      STOP:    tx_out_d = 1'b1;
      default: tx_out_d = 1'b1;
    endcase
  end

  // State register for everything above; reset drops any frame and held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      div_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      tx_out_q     <= 1'b1;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      tx_out_q     <= tx_out_d;
      overflow_q   <= overflow_d;
    end
  end

  assign tx_out      = tx_out_q;
  assign tx_overflow = overflow_q;
  assign tx_busy     = (state_q != IDLE) | hold_valid_q;

endmodule

// File: tb/tb_uart_tx_piso.sv
// Self-checking bench for uart_tx_piso: one instance at CLK_DIV=1 and one at
// CLK_DIV=4 share the same stimulus. A cycle-budget reference model tracks
// both; directed tables and sequences cover the framing corner cases.
module tb_uart_tx_piso;

  localparam int W  = 64;
  localparam int NB = W + 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-2:0] tx_data;
  logic         ld_tx_data;
  logic         tx_enable;
  logic         tx_out1;
  logic         busy1;
  logic         ovf1;
  logic         tx_out4;
  logic         busy4;
  logic         ovf4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_piso #(.WIDTH(W), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .ld_tx_data(ld_tx_data),
    .tx_enable(tx_enable), .tx_out(tx_out1), .tx_busy(busy1), .tx_overflow(ovf1)
  );

  uart_tx_piso #(.WIDTH(W), .CLK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .ld_tx_data(ld_tx_data),
    .tx_enable(tx_enable), .tx_out(tx_out4), .tx_busy(busy4), .tx_overflow(ovf4)
  );

  // Expected serial frame, bit 0 first on the line: start, data, parity, stop.
  function automatic logic [NB-1:0] frameOf(input logic [W-2:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  task automatic checkOutput(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutputWide(input string name, input logic [131:0] act, input logic [131:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutputInt(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then return at the following falling edge.
  task automatic applyStimulus(input logic rst, input logic ld, input logic en, input logic [W-2:0] d);
    reset      = rst;
    ld_tx_data = ld;
    tx_enable  = en;
    tx_data    = d;
    @(negedge clk);
  endtask

  // Reference model: each port is a count of frame cycles still owed plus the
  // frame bits; the line shows frame bit (elapsed / divider) one cycle late.
  int           m_rem   [2];
  logic         m_hv    [2];
  logic [W-2:0] m_hd    [2];
  logic [NB-1:0] m_frame [2];
  logic         m_out   [2];
  logic         m_ov    [2];
  bit           m_ready = 1'b0;
  int           m_div;
  int           m_span;
  int           m_elapsed;
  logic         m_xfer;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_div  = (i == 0) ? 1 : 4;
      m_span = NB * m_div;
      if (reset) begin
        m_rem[i] = 0;
        m_hv[i]  = 1'b0;
        m_out[i] = 1'b1;
        m_ov[i]  = 1'b0;
        m_ready  = 1'b1;
      end else begin
        m_elapsed = m_span - m_rem[i];
        m_out[i]  = (m_rem[i] > 0) ? m_frame[i][m_elapsed / m_div] : 1'b1;
        m_xfer    = m_hv[i] && tx_enable && (m_rem[i] <= 1);
        m_ov[i]   = ld_tx_data && tx_enable && m_hv[i] && !m_xfer;
        if (m_xfer) begin
          m_frame[i] = frameOf(m_hd[i]);
          m_rem[i]   = m_span;
          m_hv[i]    = 1'b0;
        end else if (m_rem[i] > 0) begin
          m_rem[i] = m_rem[i] - 1;
        end
        if (ld_tx_data && tx_enable && !m_hv[i]) begin
          m_hv[i] = 1'b1;
          m_hd[i] = tx_data;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      checkOutput("model div1 tx_out", tx_out1, m_out[0]);
      checkOutput("model div1 tx_busy", busy1, (m_rem[0] > 0) || m_hv[0]);
      checkOutput("model div1 tx_overflow", ovf1, m_ov[0]);
      checkOutput("model div4 tx_out", tx_out4, m_out[1]);
      checkOutput("model div4 tx_busy", busy4, (m_rem[1] > 0) || m_hv[1]);
      checkOutput("model div4 tx_overflow", ovf4, m_ov[1]);
    end
  end

  task automatic waitIdle();
    int n;
    n = 0;
    while ((busy1 || busy4) && n < 2000) begin
      applyStimulus(1'b0, 1'b0, 1'b1, tx_data);
      n++;
    end
    checkOutput("idle wait bound", busy1 || busy4, 1'b0);
  endtask

  // Load one word into the CLK_DIV=1 port and record its line output.
  task automatic captureFrame(input logic [W-2:0] d, output logic pre, output logic [NB-1:0] bits,
                              output int busy_n);
    busy_n = 0;
    applyStimulus(1'b0, 1'b1, 1'b1, d);
    if (busy1) busy_n++;
    applyStimulus(1'b0, 1'b0, 1'b1, d);
    pre = tx_out1;
    if (busy1) busy_n++;
    for (int k = 0; k < NB; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, d);
      bits[k] = tx_out1;
      if (busy1) busy_n++;
    end
  endtask

  typedef struct {
    logic [W-2:0] data;
    logic         exp_par;
    logic         exp_b0;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [NB-1:0]  bits;
    logic           pre;
    int             busy_n;
    logic [131:0]   wide;
    int             ov_n;
    logic           ov_at;
    logic           high_ok;
    logic [3:0]     grp;
    logic [NB-1:0]  exp4;
    logic [63:0]    r;
    logic           en_r;
    logic [W-2:0]   wa;
    logic [W-2:0]   wb;
    logic [W-2:0]   wc;

    vecs[0] = '{63'h0, 1'b1, 1'b0};
    vecs[1] = '{63'h1, 1'b0, 1'b1};
    vecs[2] = '{63'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
    vecs[3] = '{63'h5555_5555_5555_5555, 1'b1, 1'b1};
    vecs[4] = '{63'h3, 1'b1, 1'b1};
    vecs[5] = '{63'h4000_0000_0000_0000, 1'b0, 1'b0};

    wa = 63'h0123_4567_89AB_CDEF;
    wb = 63'h7EDC_BA98_7654_3210;
    wc = 63'h2222_3333_4444_5555;

    reset = 1'b1; ld_tx_data = 1'b0; tx_enable = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset tx_out", tx_out1, 1'b1);
    checkOutput("reset tx_busy", busy1, 1'b0);
    checkOutput("reset tx_overflow", ovf1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);

    $display("[TB] frame table");
    for (int v = 0; v < 6; v++) begin
      waitIdle();
      captureFrame(vecs[v].data, pre, bits, busy_n);
      checkOutput("line idle before start", pre, 1'b1);
      checkOutput("start bit", bits[0], 1'b0);
      checkOutput("first data bit", bits[1], vecs[v].exp_b0);
      checkOutputWide("data bits", 132'(bits[NB-3:1]), 132'(vecs[v].data));
      checkOutput("parity bit", bits[NB-2], vecs[v].exp_par);
      checkOutput("stop bit", bits[NB-1], 1'b1);
      checkOutputInt("busy cycles", busy_n, 67);
    end

    $display("[TB] divider");
    waitIdle();
    exp4 = frameOf(vecs[3].data);
    grp = '0;
    applyStimulus(1'b0, 1'b1, 1'b1, vecs[3].data);
    applyStimulus(1'b0, 1'b0, 1'b1, vecs[3].data);
    checkOutput("div4 idle before start", tx_out4, 1'b1);
    for (int k = 0; k < NB * 4; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, vecs[3].data);
      grp[k % 4] = tx_out4;
      if (k % 4 == 3) checkOutputWide("div4 bit held 4 cycles", 132'(grp), 132'({4{exp4[k / 4]}}));
      if (k == NB * 4 - 2) checkOutput("div4 busy at frame end", busy4, 1'b1);
      if (k == NB * 4 - 1) checkOutput("div4 busy after 264 cycles", busy4, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, vecs[3].data);
    checkOutput("div4 line idle after frame", tx_out4, 1'b1);

    $display("[TB] back-to-back and overflow");
    waitIdle();
    ov_n = 0; ov_at = 1'b0; wide = '0;
    for (int c = 0; c < 136; c++) begin
      applyStimulus(1'b0, (c == 0) || (c == 3) || (c == 6), 1'b1, (c == 0) ? wa : ((c == 3) ? wb : wc));
      if (c >= 2 && c < 134) wide[c - 2] = tx_out1;
      if (ovf1) ov_n++;
      if (c == 6) ov_at = ovf1;
      if (c == 132) checkOutput("b2b busy before end", busy1, 1'b1);
      if (c == 133) checkOutput("b2b busy falls", busy1, 1'b0);
    end
    checkOutputWide("b2b frames with no gap", wide, {frameOf(wb), frameOf(wa)});
    checkOutputInt("overflow pulse count", ov_n, 1);
    checkOutput("overflow after dropped load", ov_at, 1'b1);

    $display("[TB] enable handling");
    waitIdle();
    ov_n = 0; high_ok = 1'b1; wide = '0;
    for (int c = 0; c < 170; c++) begin
      applyStimulus(1'b0, (c == 0) || (c == 3) || (c == 20) || (c == 80), (c < 10) || (c >= 100),
                    (c == 0) ? wa : ((c == 3) ? wb : wc));
      if (c >= 2 && c < 68) wide[c - 2] = tx_out1;
      if (c >= 68 && c < 101 && tx_out1 !== 1'b1) high_ok = 1'b0;
      if (c >= 101 && c < 167) wide[c - 101 + NB] = tx_out1;
      if (ovf1) ov_n++;
      if (c == 90) checkOutput("disabled port keeps held word", busy1, 1'b1);
      if (c == 166) checkOutput("enable busy falls", busy1, 1'b0);
    end
    checkOutputWide("enable frames", wide, {frameOf(wb), frameOf(wa)});
    checkOutput("line high while disabled", high_ok, 1'b1);
    checkOutputInt("no overflow while disabled", ov_n, 0);

    $display("[TB] reset mid-frame");
    waitIdle();
    for (int c = 0; c < 25; c++) begin
      applyStimulus(c == 20, (c == 0) || (c == 3) || (c == 19), 1'b1, (c == 0) ? wa : ((c == 3) ? wb : wc));
      if (c == 19) checkOutput("overflow before reset", ovf1, 1'b1);
      if (c == 20) begin
        checkOutput("reset mid-frame tx_out", tx_out1, 1'b1);
        checkOutput("reset mid-frame tx_busy", busy1, 1'b0);
        checkOutput("reset mid-frame tx_overflow", ovf1, 1'b0);
      end
      if (c == 24) begin
        checkOutput("held word discarded", busy1, 1'b0);
        checkOutput("line idle after reset", tx_out1, 1'b1);
      end
    end
    captureFrame(wc, pre, bits, busy_n);
    checkOutput("post-reset idle before start", pre, 1'b1);
    checkOutputWide("post-reset clean frame", 132'(bits), 132'(frameOf(wc)));
    checkOutputInt("post-reset busy cycles", busy_n, 67);

    $display("[TB] random traffic");
    waitIdle();
    en_r = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      r = {$urandom(), $urandom()};
      if ($urandom_range(0, 99) == 0) en_r = ~en_r;
      applyStimulus($urandom_range(0, 799) == 0, $urandom_range(0, 5) == 0, en_r, r[W-2:0]);
    end
    for (int c = 0; c < 600; c++) begin
      r = {$urandom(), $urandom()};
      applyStimulus(1'b0, $urandom_range(0, 1) == 0, $urandom_range(0, 9) != 0, r[W-2:0]);
    end
    waitIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
